// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and FSM state type shared by the execute-stage ALU
package alu_pkg;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_RSV = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  typedef enum logic {IDLE, BUSY} alu_state_t;
endpackage

// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: operand/result handshake bundle; master drives in_valid/op/a/b/out_ready, slave drives in_ready/out_valid/result/zero/overflow
interface alu_exec_unit_if #(parameter int WIDTH = 32);
  logic in_valid, in_ready, out_valid, out_ready, zero, overflow;
  logic [2:0] op;
  logic [WIDTH-1:0] a, b, result;
  modport master(output in_valid, op, a, b, out_ready, input in_ready, out_valid, result, zero, overflow);
  modport slave(input in_valid, op, a, b, out_ready, output in_ready, out_valid, result, zero, overflow);
endinterface

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: shift-add multiplier (clk, rst, start, a, b -> done pulse, low WIDTH bits of product); bit 0 is folded into the start cycle so done rises WIDTH-1 cycles after start
module alu_mul_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d;
  always_comb begin
    acc_d = acc_q;
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    cnt_d = cnt_q;
    busy_d = busy_q;
    done = busy_q && cnt_q == CNT_W'(WIDTH);
    if (start) begin
      acc_d = b[0] ? a : '0;
      mcand_d = a << 1;
      mplier_d = b >> 1;
      cnt_d = CNT_W'(1);
      busy_d = 1'b1;
    end else if (done) begin
      cnt_d = '0;
      busy_d = 1'b0;
    end else if (busy_q) begin
      acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      mcand_q <= '0;
      mplier_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
    end
  end
  assign product = acc_q;
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked WIDTH-bit execute ALU (clk, rst, slave bus) with registered result/zero/overflow; ALU_MUL_EN adds the iterative MUL
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int MUL_CNT_W = $clog2(WIDTH) + 1
) (
  input logic clk,
  input logic rst,
  alu_exec_unit_if.slave bus
);
  logic sub, add_ovf, alu_ovf, fire, done, done_ovf;
  logic [WIDTH-1:0] bb, sum, alu_res, done_res, result_q, result_d;
  logic out_valid_q, out_valid_d, zero_q, zero_d, ovf_q, ovf_d;
  if (WIDTH < 2 || MUL_CNT_W < 1) $error("alu_exec_unit: WIDTH must be >= 2 and MUL_CNT_W >= 1");
  assign fire = bus.in_valid && bus.in_ready;
  always_comb begin
    sub = bus.op == ALU_SUB || bus.op == ALU_SLT;
    bb = sub ? ~bus.b : bus.b;
    sum = bus.a + bb + WIDTH'(sub);
    add_ovf = bus.a[WIDTH-1] == bb[WIDTH-1] && sum[WIDTH-1] != bus.a[WIDTH-1];
    alu_ovf = (bus.op == ALU_ADD || bus.op == ALU_SUB) && add_ovf;
    alu_res = bus.op == ALU_AND ? bus.a & bus.b :
              bus.op == ALU_OR  ? bus.a | bus.b :
              bus.op == ALU_NOR ? ~(bus.a | bus.b) :
              (bus.op == ALU_ADD || bus.op == ALU_SUB) ? sum :
              bus.op == ALU_SLT ? WIDTH'(sum[WIDTH-1] ^ add_ovf) : '0;
  end
`ifdef ALU_MUL_EN
  alu_state_t state_q, state_d;
  logic mul_start, mul_done;
  logic [WIDTH-1:0] product;
  assign bus.in_ready = state_q == IDLE && (!out_valid_q || bus.out_ready) && !rst;
  assign mul_start = fire && bus.op == ALU_MUL;
  alu_mul_iter #(.WIDTH(WIDTH), .CNT_W(MUL_CNT_W)) u_mul (
    .clk(clk), .rst(rst), .start(mul_start), .a(bus.a), .b(bus.b), .done(mul_done), .product(product)
  );
  always_comb begin
    state_d = mul_start ? BUSY : mul_done ? IDLE : state_q;
    done = (fire && !mul_start) || mul_done;
    done_res = mul_done ? product : alu_res;
    done_ovf = !mul_done && alu_ovf;
  end
  always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;
`else
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  always_comb begin
    done = fire;
    done_res = alu_res;
    done_ovf = alu_ovf;
  end
`endif
  always_comb begin
    result_d = done ? done_res : result_q;
    zero_d = done ? done_res == '0 : zero_q;
    ovf_d = done ? done_ovf : ovf_q;
    out_valid_d = done || (out_valid_q && !bus.out_ready);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      zero_q <= 1'b0;
      ovf_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q <= zero_d;
      ovf_q <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign bus.result = result_q;
  assign bus.zero = zero_q;
  assign bus.overflow = ovf_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: randomized scoreboard bench for alu_exec_unit plus directed latency/backpressure/reset scenarios
module tb_alu_exec_unit;
  import alu_pkg::*;
  typedef struct packed {logic [31:0] r; logic z; logic v;} exp_t;
  logic clk = 0, rst = 1, rnd_ready = 0, rr = 1, dir_ready = 1;
  int errors = 0, checks = 0, w;
  exp_t sb[$];
  exp_t mon_e;
  alu_exec_unit_if #(.WIDTH(32)) bus();
  alu_exec_unit #(.WIDTH(32)) dut(.clk(clk), .rst(rst), .bus(bus.slave));
  assign bus.out_ready = rnd_ready ? rr : dir_ready;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1 rr = $urandom_range(0, 3) != 0;
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic exp_t model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, s;
    logic [31:0] r;
    exp_t e;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    s = 0;
    r = 0;
    case (o)
      ALU_AND: r = x & y;
      ALU_OR:  r = x | y;
      ALU_NOR: r = ~(x | y);
      ALU_ADD: begin s = sx + sy; r = s[31:0]; end
      ALU_SUB: begin s = sx - sy; r = s[31:0]; end
      ALU_SLT: r = {31'b0, sx < sy};
`ifdef ALU_MUL_EN
      ALU_MUL: r = x * y;
`endif
      default: r = 0;
    endcase
    e.r = r;
    e.z = r == 0;
    e.v = (o == ALU_ADD || o == ALU_SUB) && s != longint'($signed(r));
    return e;
  endfunction
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h7fffffff;
      2: return 32'h80000000;
      3: return 32'hffffffff;
      default: return $urandom;
    endcase
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input bit push, output int n);
    n = 0;
    bus.in_valid = 1;
    bus.op = o;
    bus.a = x;
    bus.b = y;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) chk("accept_timeout", bus.in_ready, 1);
    else begin
      @(posedge clk);
      if (push) sb.push_back(model(o, x, y));
      #1;
    end
    bus.in_valid = 0;
  endtask
  task automatic single(input string nm, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] r, input logic z, input logic v);
    step();
    issue(o, x, y, 1, w);
    @(negedge clk);
    chk({nm, "_valid"}, bus.out_valid, 1);
    chk({nm, "_result"}, bus.result, r);
    chk({nm, "_zero"}, bus.zero, z);
    chk({nm, "_ovf"}, bus.overflow, v);
  endtask
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: result=%h arrived with nothing pending", bus.result);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_result", bus.result, mon_e.r);
        chk("sb_zero", bus.zero, mon_e.z);
        chk("sb_ovf", bus.overflow, mon_e.v);
      end
    end
  end
  initial begin
    bus.in_valid = 0;
    bus.op = 0;
    bus.a = 0;
    bus.b = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_zero", bus.zero, 0);
    chk("rst_ovf", bus.overflow, 0);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("idle_in_ready", bus.in_ready, 1);
    single("add_ovf", ALU_ADD, 32'h7fffffff, 32'h1, 32'h80000000, 0, 1);
    single("slt_neg", ALU_SLT, 32'h80000000, 32'h1, 32'h1, 0, 0);
    single("slt_ovf", ALU_SLT, 32'h7fffffff, 32'hffffffff, 32'h0, 1, 0);
    single("sub_eq", ALU_SUB, 32'd5, 32'd5, 32'h0, 1, 0);
    single("nor_zero", ALU_NOR, 32'h0, 32'h0, 32'hffffffff, 0, 0);
    single("rsv", ALU_RSV, 32'h1234, 32'h5678, 32'h0, 1, 0);
    step();
    for (int i = 0; i < 6; i++) begin
      issue(3'(i % 3), pick(), pick(), 1, w);
      chk("b2b_wait", w, 0);
    end
    step();
    dir_ready = 0;
    issue(ALU_AND, 32'hf0f0f0f0, 32'hff00ff00, 1, w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_result", bus.result, 32'hf000f000);
    end
    step();
    dir_ready = 1;
    issue(ALU_ADD, 32'h10, 32'h20, 1, w);
    chk("handoff_wait", w, 0);
    @(negedge clk);
    chk("handoff_valid", bus.out_valid, 1);
    chk("handoff_result", bus.result, 32'h30);
`ifdef ALU_MUL_EN
    step();
    issue(ALU_MUL, 32'h10001, 32'd3, 1, w);
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      chk("mul_in_ready", bus.in_ready, 0);
    end
    @(negedge clk);
    chk("mul_pending_valid", bus.out_valid, 0);
    @(negedge clk);
    chk("mul_valid", bus.out_valid, 1);
    chk("mul_result", bus.result, 32'h30003);
    step();
    issue(ALU_MUL, 32'h1234, 32'h5678, 0, w);
    repeat (9) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_result", bus.result, 0);
    chk("abort_in_ready", bus.in_ready, 1);
`else
    single("mul_rsv", ALU_MUL, 32'h10001, 32'd3, 32'h0, 1, 0);
`endif
    step();
    rnd_ready = 1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) step();
      issue(3'($urandom_range(0, 7)), pick(), pick(), 1, w);
    end
    rnd_ready = 0;
    dir_ready = 1;
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    chk("drain_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised, handshaked execute-stage ALU for the 5-stage pipeline CPU. It generalises the 1-bit ALU slice to a WIDTH-bit datapath and keeps the AND/OR/ADD/SUB/SLT opcode encoding. It adds NOR, overflow-correct SLT, zero and overflow flags, a registered output with valid/ready flow control, and an optional iterative multi-cycle multiply. It sits between the ID/EX register and the EX/MEM register and can stall the pipeline through `in_ready`.

## Interface
- `WIDTH`, 32: datapath width in bits, ≥ 2.
- `MUL_CNT_W`, `$clog2(WIDTH)+1`: width of the multiply iteration counter.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  operand/op presented.
- `in_ready`  out  1  unit can accept this cycle.
- `op`  in  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 100 NOR, 011 MUL, 101 reserved.
- `a`, `b`  in  WIDTH  operands; SLT, ADD and SUB treat them as two's complement.
- `out_valid`  out  1  result register holds an unconsumed result.
- `out_ready`  in  1  downstream consumes the result.
- `result`  out  WIDTH  registered result.
- `zero`  out  1  registered; `result == 0`.
- `overflow`  out  1  registered; signed overflow for ADD/SUB, otherwise 0.

## Operation
- Transfer in when `in_valid && in_ready`. Transfer out when `out_valid && out_ready`.
- `in_ready = (state == IDLE) && (!out_valid || out_ready) && !rst`. This is combinational and has no dependence on `in_valid`.
- AND, OR, NOR, ADD, SUB, SLT and reserved ops are single-cycle.
  - SUB computes `a + ~b + 1`.
  - Overflow: `(a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB])`, where `b'` is `b` for ADD and `~b` for SUB.
  - SLT result is `{WIDTH-1 zeros, sum[MSB] ^ ovf}`, using the SUB sum. The SLT overflow flag is 0.
  - Reserved op 101 produces result 0 with `zero` = 1.
- MUL returns the unsigned low WIDTH bits of `a*b` and is iterative (shift-add).
- State machine:
  - IDLE → BUSY on an accepted MUL.
  - BUSY → IDLE when the counter reaches WIDTH, loading the result register and setting `out_valid`.
  - Single-cycle ops never leave IDLE.
- The result, `zero` and `overflow` registers load only on completion. They hold stable while `out_valid && !out_ready`.
- `out_valid` clears on an out-transfer unless a new result completes on the same edge, in which case it stays 1 with the new data.
- Reset values: `out_valid` 0, `result` 0, `zero` 0, `overflow` 0, state IDLE, counter 0, multiplier accumulator 0.
- Reset asserted during BUSY aborts the multiply; no result is produced.

## Timing
- Single-cycle op accepted at edge N → `out_valid` = 1 after edge N.
- MUL accepted at edge N → `out_valid` = 1 after edge N+WIDTH. `in_ready` = 0 for the WIDTH cycles in between.
- Back-to-back: with `out_ready` held at 1, single-cycle ops sustain 1 result per cycle.
- Backpressure: `out_valid && !out_ready` forces `in_ready` = 0. No input is lost and no output is overwritten.
- Simultaneous out-transfer and in-transfer on the same edge is legal; the new result replaces the old one.

## Configuration
- `ALU_MUL_EN` defined: MUL is implemented as described above.
- `ALU_MUL_EN` undefined: the multiply sub-module and BUSY state are not compiled. Op 011 behaves as reserved: single-cycle, result 0, `zero` = 1. `in_ready` reduces to `!out_valid || out_ready`.

## Structure
- Package `alu_pkg` holds:
  - the opcode constants `ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SUB`, `ALU_SLT`, `ALU_NOR`, `ALU_MUL`, `ALU_RSV`;
  - the state typedef `alu_state_t` with members IDLE and BUSY.
- Sub-module `alu_mul_iter` is the shift-add multiplier, compiled only under `ALU_MUL_EN`.
  - Inputs: `start`, `a`, `b`.
  - Outputs: `done` (one-cycle pulse), `product`.
  - Carries its own counter. Uses the same `clk`/`rst`.
- The top level owns the handshake, the result register and the combinational logic for the single-cycle ops.

## Test plan
- WIDTH=32, ADD `a`=0x7FFFFFFF, `b`=1, `out_ready`=1 → next cycle `out_valid`=1, `result`=0x80000000, `overflow`=1, `zero`=0.
- SLT `a`=0x80000000, `b`=1 → `result`=1. SLT `a`=0x7FFFFFFF, `b`=0xFFFFFFFF → `result`=0. Checks the overflow correction.
- SUB `a`=5, `b`=5 → `result`=0, `zero`=1, `overflow`=0. NOR `a`=0, `b`=0 → `result`=0xFFFFFFFF.
- `ALU_MUL_EN` defined, MUL `a`=0x10001, `b`=3 accepted at edge N:
  - `in_ready`=0 during cycles N+1 through N+31;
  - `out_valid`=1 after edge N+32 with `result`=0x30003.
- Backpressure: hold `out_ready`=0 after an AND result:
  - `in_ready`=0 and `result` stable for 5 cycles;
  - raise `out_ready` with a new ADD valid → one-cycle handoff, no loss.
- Assert `rst` mid-MUL, at cycle N+10 → `out_valid`=0, `result`=0, `in_ready`=1 on the first cycle after `rst` deasserts.
